control_unit: RTL and testbench
===============================

# control_unit

Main decoder plus ALU-control decoder for the single-cycle MIPS-subset CPU. Takes the instruction's 6-bit opcode and 6-bit function field and produces registered datapath control strobes:
- ALU operation
- branch
- register-file write
- memory read/write
- memory-to-register select
- PC write enable

It sits between the instruction-fetch register and the datapath (ALU, register file, data memory, PC logic).

## Interface
- No parameters.
- clk  input  1  system clock; all outputs update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- op_code  input  6  instruction bits [31:26].
- func_code  input  6  instruction bits [5:0]; meaningful only when op_code = 000000.
- ALU_OP  output  4  ALU operation select.
- Branch  output  1  conditional-branch (BEQ) qualifier to PC logic.
- CNTRL_RS  output  1  register-file write enable.
- MEM_WS  output  1  data-memory write strobe.
- MEM_RS  output  1  data-memory read strobe.
- MEM_TR  output  1  write-back mux select: 1 = memory data, 0 = ALU result.
- PC_WE  output  1  program-counter write enable.
- ILLEGAL  output  1  current opcode/funct is not a supported instruction.

## Operation
ALU_OP encodings:
- AND = 0000
- OR = 0001
- ADD = 0010
- SUB = 0110
- SLT = 0111
- NOR = 1100

R-type instructions (op_code 000000):
- All R-type: CNTRL_RS=1, MEM_WS=0, MEM_RS=0, MEM_TR=0, Branch=0, PC_WE=1, ILLEGAL=0.
- ALU_OP by funct: 100000 ADD→0010; 100010 SUB→0110; 100100 AND→0000; 100101 OR→0001; 101010 SLT→0111.
- Any other funct is illegal.

I-type instructions:
- ADDI 001000: ALU_OP=0010, CNTRL_RS=1, MEM_TR=0; memory strobes 0, Branch=0.
- LW 100011: ALU_OP=0010, CNTRL_RS=1, MEM_RS=1, MEM_TR=1, MEM_WS=0, Branch=0.
- SW 101011: ALU_OP=0010, MEM_WS=1, CNTRL_RS=0, MEM_RS=0, MEM_TR=0, Branch=0.
- BEQ 000100: ALU_OP=0110, Branch=1, CNTRL_RS=0, memory strobes 0, MEM_TR=0.
- func_code is ignored for every non-R-type opcode.
- All legal instructions drive PC_WE=1 and ILLEGAL=0.

Illegal instructions (unsupported opcode or R-type funct):
- ILLEGAL=1, ALU_OP=0010.
- CNTRL_RS, MEM_WS, MEM_RS, MEM_TR, Branch all 0.
- PC_WE=1, so the PC skips the instruction; no architectural state is modified.

Decode is a pure function of the inputs sampled at the clock edge; there is no other internal state.

## Timing
- All outputs are registered; latency is exactly 1 cycle.
- Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- Inputs are consumed every cycle; there is no handshake.
- Reset: when rst=1 at a rising edge, every output goes to 0 at that edge, including ALU_OP=0000, PC_WE=0 and ILLEGAL=0. Reset takes priority over decode.
- Reset mid-stream: the instruction present at the reset edge is discarded.
- After reset: the first edge with rst=0 loads the decode of the inputs present at that edge.
- Outputs never glitch between edges.
- X/Z on op_code or func_code must not propagate: any non-matching pattern decodes as illegal.

## Configuration
- Macro CU_EXT_ISA_EN.
- When defined, the following additional instructions decode as legal:
  - ANDI 001100: ALU_OP=0000, CNTRL_RS=1.
  - ORI 001101: ALU_OP=0001, CNTRL_RS=1.
  - SLTI 001010: ALU_OP=0111, CNTRL_RS=1.
  - R-type NOR funct 100111: ALU_OP=1100, CNTRL_RS=1.
  - Each of these: memory strobes 0, MEM_TR=0, Branch=0, PC_WE=1, ILLEGAL=0.
- When undefined, these four encodings take the illegal-instruction path.
- The port list is identical in both builds.

## Test plan
- Reset: rst=1 for 2 cycles with op_code=100011 applied → all outputs 0, including PC_WE=0. Deassert rst → next edge gives LW decode: ALU_OP=0010, CNTRL_RS=1, MEM_RS=1, MEM_TR=1, PC_WE=1.
- R-type sweep: op_code=000000 with funct 100000/100010/100100/100101/101010, one per cycle → ALU_OP 0010/0110/0000/0001/0111 each one cycle later; CNTRL_RS=1; memory strobes 0; Branch=0.
- I-type sweep: ADDI, LW, SW, BEQ with func_code=000000 → values per Operation. Specifically:
  - SW: MEM_WS=1, CNTRL_RS=0.
  - BEQ: Branch=1, ALU_OP=0110, CNTRL_RS=0.
  - Repeat with func_code=111111; outputs must be identical.
- Illegal: op_code=000000/funct=000001, and op_code=111111 → ILLEGAL=1, all write strobes 0, PC_WE=1, ALU_OP=0010.
- Mid-stream reset: issue SW, assert rst at the next edge → MEM_WS is high for exactly one cycle, then 0.
- Configuration: run ANDI 001100 in both builds. With CU_EXT_ISA_EN: ALU_OP=0000, CNTRL_RS=1, ILLEGAL=0. Without: ILLEGAL=1, CNTRL_RS=0.

Source files
------------

// File: rtl/control_unit.sv
// Registered main + ALU-control decoder for the single-cycle MIPS-subset CPU.
// Define CU_EXT_ISA_EN to also decode ANDI, ORI, SLTI and R-type NOR.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code,
    input  logic [5:0] func_code,
    output logic [3:0] ALU_OP,
    output logic       Branch,
    output logic       CNTRL_RS,
    output logic       MEM_WS,
    output logic       MEM_RS,
    output logic       MEM_TR,
    output logic       PC_WE,
    output logic       ILLEGAL
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    branch;
        logic    reg_write;
        logic    mem_write;
        logic    mem_read;
        logic    mem_to_reg;
        logic    pc_we;
        logic    illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    ctrl_t dec;
    ctrl_t ctrl_q;

    // Illegal is the fall-through: any unlisted pattern, including X/Z, lands in default.
    always_comb begin
        // NOTE: every field gets a value before the case so no path can infer a latch.
        dec         = '0;
        dec.alu_op  = ALU_ADD;
        dec.pc_we   = 1'b1;
        dec.illegal = 1'b1;
        case (op_code)
            OP_RTYPE: begin
                case (func_code)
                    FN_ADD:  begin dec.alu_op = ALU_ADD; dec.illegal = 1'b0; end
                    FN_SUB:  begin dec.alu_op = ALU_SUB; dec.illegal = 1'b0; end
                    FN_AND:  begin dec.alu_op = ALU_AND; dec.illegal = 1'b0; end
                    FN_OR:   begin dec.alu_op = ALU_OR;  dec.illegal = 1'b0; end
                    FN_SLT:  begin dec.alu_op = ALU_SLT; dec.illegal = 1'b0; end
`ifdef CU_EXT_ISA_EN
                    FN_NOR:  begin dec.alu_op = ALU_NOR; dec.illegal = 1'b0; end
`endif
                    default: dec.illegal = 1'b1;
                endcase
                dec.reg_write = ~dec.illegal;
            end
            OP_ADDI: begin dec.illegal = 1'b0; dec.reg_write = 1'b1; end
            OP_LW: begin
                dec.illegal    = 1'b0;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OP_SW:  begin dec.illegal = 1'b0; dec.mem_write = 1'b1; end
            OP_BEQ: begin dec.illegal = 1'b0; dec.alu_op = ALU_SUB; dec.branch = 1'b1; end
`ifdef CU_EXT_ISA_EN
            OP_ANDI: begin dec.illegal = 1'b0; dec.alu_op = ALU_AND; dec.reg_write = 1'b1; end
            OP_ORI:  begin dec.illegal = 1'b0; dec.alu_op = ALU_OR;  dec.reg_write = 1'b1; end
            OP_SLTI: begin dec.illegal = 1'b0; dec.alu_op = ALU_SLT; dec.reg_write = 1'b1; end
`endif
            default: dec.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every strobe updates together on the edge.
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= dec;
    end

    assign ALU_OP   = ctrl_q.alu_op;
    assign Branch   = ctrl_q.branch;
    assign CNTRL_RS = ctrl_q.reg_write;
    assign MEM_WS   = ctrl_q.mem_write;
    assign MEM_RS   = ctrl_q.mem_read;
    assign MEM_TR   = ctrl_q.mem_to_reg;
    assign PC_WE    = ctrl_q.pc_we;
    assign ILLEGAL  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, reset sequences,
// and randomized traffic against an instruction-table reference model.
module tb_control_unit;

    // {alu_op, branch, reg_write, mem_ws, mem_rs, mem_tr, pc_we, illegal}
    typedef struct packed {
        logic [3:0] alu;
        logic       br;
        logic       rw;
        logic       mw;
        logic       mr;
        logic       mt;
        logic       pcwe;
        logic       ill;
    } exp_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        exp_t       e;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic       rtype;
        logic [5:0] fn;
        exp_t       e;
    } isa_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op_code = 6'b100011;
    logic [5:0] func_code = 6'b000000;
    logic [3:0] ALU_OP;
    logic       Branch, CNTRL_RS, MEM_WS, MEM_RS, MEM_TR, PC_WE, ILLEGAL;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    isa_t isa[$];

    localparam exp_t ZERO = '0;
    localparam exp_t ILL  = '{alu: 4'b0010, br: 1'b0, rw: 1'b0, mw: 1'b0, mr: 1'b0,
                              mt: 1'b0, pcwe: 1'b1, ill: 1'b1};

    control_unit dut (
        .clk(clk), .rst(rst), .op_code(op_code), .func_code(func_code),
        .ALU_OP(ALU_OP), .Branch(Branch), .CNTRL_RS(CNTRL_RS), .MEM_WS(MEM_WS),
        .MEM_RS(MEM_RS), .MEM_TR(MEM_TR), .PC_WE(PC_WE), .ILLEGAL(ILLEGAL)
    );

    always #5 clk = ~clk;

    function automatic exp_t legal(input logic [3:0] alu, input logic br, input logic rw,
                                   input logic mw, input logic mr, input logic mt);
        exp_t e;
        e = '{alu: alu, br: br, rw: rw, mw: mw, mr: mr, mt: mt, pcwe: 1'b1, ill: 1'b0};
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = '{alu: ALU_OP, br: Branch, rw: CNTRL_RS, mw: MEM_WS, mr: MEM_RS,
              mt: MEM_TR, pcwe: PC_WE, ill: ILLEGAL};
        return a;
    endfunction

    // Reference model: look the instruction up in the supported-ISA list.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn);
        exp_t e = ILL;
        foreach (isa[i])
            if (isa[i].op == op && (!isa[i].rtype || isa[i].fn == fn)) e = isa[i].e;
        return e;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (alu br rw mw mr mt pcwe ill)", name, act, exp);
        end
    endtask

    // Drive away from the rising edge, then sample just after it.
    task automatic apply(input logic r, input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        rst = r; op_code = op; func_code = fn;
        @(posedge clk);
        #1;
    endtask

    task automatic add_isa(input logic [5:0] op, input logic rtype, input logic [5:0] fn,
                           input exp_t e);
        isa_t t;
        t.op = op; t.rtype = rtype; t.fn = fn; t.e = e;
        isa.push_back(t);
    endtask

    task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input exp_t e);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t exp_andi;
        logic [5:0] ops [9] = '{6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h0c, 6'h0d, 6'h0a, 6'h3f};
        logic [5:0] fns [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h01};

        add_isa(6'b000000, 1'b1, 6'b100000, legal(4'b0010, 0, 1, 0, 0, 0));
        add_isa(6'b000000, 1'b1, 6'b100010, legal(4'b0110, 0, 1, 0, 0, 0));
        add_isa(6'b000000, 1'b1, 6'b100100, legal(4'b0000, 0, 1, 0, 0, 0));
        add_isa(6'b000000, 1'b1, 6'b100101, legal(4'b0001, 0, 1, 0, 0, 0));
        add_isa(6'b000000, 1'b1, 6'b101010, legal(4'b0111, 0, 1, 0, 0, 0));
        add_isa(6'b001000, 1'b0, 6'b000000, legal(4'b0010, 0, 1, 0, 0, 0));
        add_isa(6'b100011, 1'b0, 6'b000000, legal(4'b0010, 0, 1, 0, 1, 1));
        add_isa(6'b101011, 1'b0, 6'b000000, legal(4'b0010, 0, 0, 1, 0, 0));
        add_isa(6'b000100, 1'b0, 6'b000000, legal(4'b0110, 1, 0, 0, 0, 0));
`ifdef CU_EXT_ISA_EN
        add_isa(6'b001100, 1'b0, 6'b000000, legal(4'b0000, 0, 1, 0, 0, 0));
        add_isa(6'b001101, 1'b0, 6'b000000, legal(4'b0001, 0, 1, 0, 0, 0));
        add_isa(6'b001010, 1'b0, 6'b000000, legal(4'b0111, 0, 1, 0, 0, 0));
        add_isa(6'b000000, 1'b1, 6'b100111, legal(4'b1100, 0, 1, 0, 0, 0));
        exp_andi = legal(4'b0000, 0, 1, 0, 0, 0);
`else
        exp_andi = ILL;
`endif

        add_vec("r_add", 6'b000000, 6'b100000, legal(4'b0010, 0, 1, 0, 0, 0));
        add_vec("r_sub", 6'b000000, 6'b100010, legal(4'b0110, 0, 1, 0, 0, 0));
        add_vec("r_and", 6'b000000, 6'b100100, legal(4'b0000, 0, 1, 0, 0, 0));
        add_vec("r_or",  6'b000000, 6'b100101, legal(4'b0001, 0, 1, 0, 0, 0));
        add_vec("r_slt", 6'b000000, 6'b101010, legal(4'b0111, 0, 1, 0, 0, 0));
        for (int k = 0; k < 2; k++) begin
            logic [5:0] f = (k == 0) ? 6'b000000 : 6'b111111;
            add_vec("addi", 6'b001000, f, legal(4'b0010, 0, 1, 0, 0, 0));
            add_vec("lw",   6'b100011, f, legal(4'b0010, 0, 1, 0, 1, 1));
            add_vec("sw",   6'b101011, f, legal(4'b0010, 0, 0, 1, 0, 0));
            add_vec("beq",  6'b000100, f, legal(4'b0110, 1, 0, 0, 0, 0));
        end
        add_vec("ill_funct", 6'b000000, 6'b000001, ILL);
        add_vec("ill_op",    6'b111111, 6'b000000, ILL);
        add_vec("andi",      6'b001100, 6'b000000, exp_andi);
        add_vec("lw_after_ill", 6'b100011, 6'b101010, legal(4'b0010, 0, 1, 0, 1, 1));

        // Reset held two cycles with LW on the inputs, then released.
        apply(1'b1, 6'b100011, 6'b000000);
        check("reset_c1", actual(), ZERO);
        apply(1'b1, 6'b100011, 6'b000000);
        check("reset_c2", actual(), ZERO);
        apply(1'b0, 6'b100011, 6'b000000);
        check("lw_after_reset", actual(), legal(4'b0010, 0, 1, 0, 1, 1));

        foreach (vecs[i]) begin
            apply(1'b0, vecs[i].op, vecs[i].fn);
            check(vecs[i].name, actual(), vecs[i].e);
        end

        // Mid-stream reset: SW strobe lasts one cycle, LW under reset is discarded.
        apply(1'b0, 6'b101011, 6'b000000);
        check("sw_before_reset", actual(), legal(4'b0010, 0, 0, 1, 0, 0));
        apply(1'b1, 6'b101011, 6'b000000);
        check("sw_reset_edge", actual(), ZERO);
        apply(1'b1, 6'b100011, 6'b000000);
        check("lw_discarded", actual(), ZERO);
        apply(1'b0, 6'b000100, 6'b111111);
        check("beq_after_reset", actual(), legal(4'b0110, 1, 0, 0, 0, 0));

        // Randomized traffic biased towards interesting encodings.
        for (int n = 0; n < 400; n++) begin
            logic [5:0] op, fn;
            logic       r;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            r  = ($urandom_range(0, 19) == 0);
            apply(r, op, fn);
            check($sformatf("rand%0d op=%b fn=%b rst=%b", n, op, fn, r), actual(),
                  r ? ZERO : model(op, fn));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
